// File: rtl/sdf_flow_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sdf_flow_scheduler
// Description : Round-robin burst scheduler sharing one multi-flow SDF actor
//               between N_FLOWS input FIFOs. One flow is granted for a whole
//               firing of BURST tokens, whose tokens are forwarded with zero
//               latency to the actor input FIFO, tagged with the flow index.
//               A granted flow that runs dry for TIMEOUT consecutive cycles
//               is released, and a one-cycle abandon pulse is raised.
// Ports       : ck        - clock, all logic on the rising edge
//               rst       - synchronous active-high reset
//               in_data   - flow i payload at [i*WIDTH +: WIDTH]
//               in_empty  - per-flow FIFO empty flags
//               in_read   - per-flow pop strobes (one-hot or zero)
//               cfg_en    - per-flow arbitration enables
//               full      - actor input FIFO full
//               wr        - push out_data/out_tag into the actor FIFO
//               out_data  - forwarded payload
//               out_tag   - index of the flow that produced out_data
//               busy      - registered: a flow is currently granted
//               abandon   - registered 1-cycle pulse: burst timed out
// Revision    : 1.0 - initial release
// ============================================================================
module sdf_flow_scheduler #(
    parameter int WIDTH   = 8,
    parameter int N_FLOWS = 2,
    parameter int BURST   = 4,
    parameter int TIMEOUT = 16,
    localparam int TAG_W  = $clog2(N_FLOWS)
) (
    input  logic                     ck,
    input  logic                     rst,
    input  logic [N_FLOWS*WIDTH-1:0] in_data,
    input  logic [N_FLOWS-1:0]       in_empty,
    output logic [N_FLOWS-1:0]       in_read,
    input  logic [N_FLOWS-1:0]       cfg_en,
    input  logic                     full,
    output logic                     wr,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     busy,
    output logic                     abandon
);

    localparam logic [7:0]       c_CNT_LAST  = 8'(BURST - 1);
    localparam logic [7:0]       c_TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [TAG_W-1:0] c_LAST_INIT = TAG_W'(N_FLOWS - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t             state_q;
    logic [TAG_W-1:0]   grant_q;
    logic [TAG_W-1:0]   last_q;
    logic [7:0]         cnt_q;
    logic [7:0]         tmo_q;
    logic               busy_q;
    logic               abandon_q;

    logic               w_in_burst;
    logic               w_empty_g;
    logic               w_xfer;
    logic               w_found;
    logic [TAG_W-1:0]   w_pick;
    logic [N_FLOWS-1:0] w_read;

    // ------------------------------------------------------------------------
    // Round-robin search starting just after the last served flow. The modulo
    // keeps the search inside 0..N_FLOWS-1, so unused tag codes are never
    // granted when N_FLOWS is not a power of two.
    // ------------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= N_FLOWS; k++) begin
            if (!w_found
                && cfg_en[(int'(last_q) + k) % N_FLOWS]
                && !in_empty[(int'(last_q) + k) % N_FLOWS]) begin
                w_found = 1'b1;
                w_pick  = TAG_W'((int'(last_q) + k) % N_FLOWS);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Zero-latency forwarding path from the granted FIFO to the actor FIFO.
    // ------------------------------------------------------------------------
    assign w_in_burst = (state_q == S_BURST);
    assign w_empty_g  = in_empty[grant_q];
    assign w_xfer     = w_in_burst & ~w_empty_g & ~full;

    always_comb begin
        w_read = '0;
        if (w_xfer) begin
            w_read[grant_q] = 1'b1;
        end
    end

    assign in_read  = w_read;
    assign wr       = w_xfer;
    assign out_data = w_in_burst ? in_data[int'(grant_q)*WIDTH +: WIDTH] : '0;
    assign out_tag  = w_in_burst ? grant_q : '0;
    assign busy     = busy_q;
    assign abandon  = abandon_q;

    // ------------------------------------------------------------------------
    // Grant state machine. Backpressure (full with data available) holds both
    // counters, so only a dry FIFO can time a burst out.
    // ------------------------------------------------------------------------
    always_ff @(posedge ck) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_q    <= c_LAST_INIT;
            cnt_q     <= '0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
            abandon_q <= 1'b0;
        end else begin
            abandon_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_found) begin
                        grant_q <= w_pick;
                        cnt_q   <= '0;
                        tmo_q   <= '0;
                        state_q <= S_BURST;
                        busy_q  <= 1'b1;
                    end
                end
                S_BURST: begin
                    if (w_xfer) begin
                        if (cnt_q == c_CNT_LAST) begin
                            last_q  <= grant_q;
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                            tmo_q <= '0;
                        end
                    end else if (w_empty_g) begin
                        tmo_q <= tmo_q + 8'd1;
                        if (tmo_q == c_TMO_LAST) begin
                            abandon_q <= 1'b1;
                            last_q    <= grant_q;
                            state_q   <= S_IDLE;
                            busy_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdf_flow_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdf_flow_scheduler
// Description : Self-checking bench for sdf_flow_scheduler. Per-flow input
//               FIFOs are modelled as queues; a transaction-level reference
//               (granted flow, tokens served, dry cycles seen) predicts every
//               output each cycle. Directed phases are followed by random
//               traffic with backpressure, enable changes and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdf_flow_scheduler;

    localparam int WIDTH   = 8;
    localparam int N       = 2;
    localparam int BURST   = 4;
    localparam int TIMEOUT = 16;
    localparam int TAG_W   = 1;

    typedef logic [WIDTH-1:0] tok_q_t[$];

    logic               ck = 1'b0;
    logic               rst;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_empty;
    logic [N-1:0]       in_read;
    logic [N-1:0]       cfg_en;
    logic               full;
    logic               wr;
    logic [WIDTH-1:0]   out_data;
    logic [TAG_W-1:0]   out_tag;
    logic               busy;
    logic               abandon;

    sdf_flow_scheduler #(
        .WIDTH   (WIDTH),
        .N_FLOWS (N),
        .BURST   (BURST),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .ck       (ck),
        .rst      (rst),
        .in_data  (in_data),
        .in_empty (in_empty),
        .in_read  (in_read),
        .cfg_en   (cfg_en),
        .full     (full),
        .wr       (wr),
        .out_data (out_data),
        .out_tag  (out_tag),
        .busy     (busy),
        .abandon  (abandon)
    );

    always #5 ck = ~ck;

    // Stimulus FIFOs and reference state
    tok_q_t q [N];
    bit     m_granted;
    int     m_flow;
    int     m_last;
    int     m_served;
    int     m_dry;
    bit     m_abandon;
    int     n_abandons;
    int     n_tokens;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_granted = 1'b0;
        m_flow    = 0;
        m_last    = N - 1;
        m_served  = 0;
        m_dry     = 0;
        m_abandon = 1'b0;
    endtask

    task automatic push(input int f, input logic [WIDTH-1:0] v);
        if (q[f].size() < 16) q[f].push_back(v);
    endtask

    // One clock cycle: present FIFO state, check outputs mid-cycle, then
    // advance the reference after the edge. Called at posedge+1.
    task automatic cycle();
        bit           xfer;
        logic [N-1:0] exp_rd;
        for (int i = 0; i < N; i++) begin
            in_empty[i] = (q[i].size() == 0);
            in_data[i*WIDTH +: WIDTH] = (q[i].size() == 0) ? 8'hA5 : q[i][0];
        end
        #3;
        xfer   = m_granted && (q[m_flow].size() > 0) && !full;
        exp_rd = '0;
        if (xfer) exp_rd[m_flow] = 1'b1;
        check("in_read",  32'(in_read),  32'(exp_rd));
        check("wr",       32'(wr),       32'(xfer));
        check("out_tag",  32'(out_tag),  m_granted ? 32'(m_flow) : 32'd0);
        check("out_data", 32'(out_data),
              m_granted ? 32'(in_data[m_flow*WIDTH +: WIDTH]) : 32'd0);
        check("busy",     32'(busy),     32'(m_granted));
        check("abandon",  32'(abandon),  32'(m_abandon));
        @(posedge ck);
        #1;
        m_abandon = 1'b0;
        if (xfer) begin
            void'(q[m_flow].pop_front());
            n_tokens++;
        end
        if (rst) begin
            model_reset();
        end else if (m_granted) begin
            if (xfer) begin
                m_served++;
                m_dry = 0;
                if (m_served == BURST) begin
                    m_granted = 1'b0;
                    m_last    = m_flow;
                end
            end else if (q[m_flow].size() == 0) begin
                m_dry++;
                if (m_dry == TIMEOUT) begin
                    m_granted = 1'b0;
                    m_abandon = 1'b1;
                    m_last    = m_flow;
                    n_abandons++;
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (!m_granted && cfg_en[(m_last + k) % N] && q[(m_last + k) % N].size() > 0) begin
                    m_granted = 1'b1;
                    m_flow    = (m_last + k) % N;
                    m_served  = 0;
                    m_dry     = 0;
                end
            end
        end
    endtask

    task automatic run_until_served(input int f, input int n);
        int guard;
        guard = 0;
        while (!(m_granted && m_flow == f && m_served == n) && guard < 200) begin
            cycle();
            guard++;
        end
        check("reach_burst_point", 32'(guard < 200), 32'd1);
    endtask

    initial begin
        int rate;
        n_abandons = 0;
        n_tokens   = 0;
        rst      = 1'b1;
        full     = 1'b0;
        cfg_en   = 2'b11;
        in_empty = '1;
        in_data  = '0;
        @(posedge ck);
        #1;
        model_reset();
        rst = 1'b0;

        // Idle after reset with nothing queued
        for (int c = 0; c < 10; c++) cycle();

        // Both flows loaded: alternating bursts with one idle cycle between
        for (int i = 0; i < 8; i++) begin
            push(0, 8'(8'h01 + i));
            push(1, 8'(8'h11 + i));
        end
        for (int c = 0; c < 24; c++) cycle();

        // Backpressure after the 2nd token of a flow-0 burst
        for (int i = 0; i < 4; i++) push(0, 8'(8'h21 + i));
        run_until_served(0, 2);
        full = 1'b1;
        for (int c = 0; c < 5; c++) cycle();
        full = 1'b0;
        for (int c = 0; c < 6; c++) cycle();

        // Flow 1 runs dry after one token; flow 0 waiting behind it
        push(1, 8'h31);
        run_until_served(1, 0);
        cycle();
        for (int i = 0; i < 4; i++) push(0, 8'(8'h41 + i));
        for (int c = 0; c < 24; c++) cycle();
        check("timeout_seen", 32'(n_abandons > 0), 32'd1);

        // Only flow 1 enabled; clear its enable mid-burst
        cfg_en = 2'b10;
        for (int i = 0; i < 4; i++) begin
            push(0, 8'(8'h51 + i));
            push(1, 8'(8'h61 + i));
        end
        run_until_served(1, 1);
        cfg_en = 2'b00;
        for (int c = 0; c < 10; c++) cycle();
        cfg_en = 2'b11;

        // Reset in the middle of a burst
        while (q[0].size() < 6) push(0, 8'($urandom));
        while (q[1].size() < 6) push(1, 8'($urandom));
        run_until_served(q[0].size() > 0 && m_last == 1 ? 0 : m_flow, 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) cycle();

        // Random traffic with varying fill rates
        rate = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) rate = $urandom_range(5, 95);
            for (int f = 0; f < N; f++) begin
                if ($urandom_range(0, 99) < rate) push(f, 8'($urandom));
            end
            full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) cfg_en = 2'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            cycle();
        end
        rst = 1'b0;
        check("tokens_moved", 32'(n_tokens > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
